// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared types and helpers for the handshake priority encoder
package prio_enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Widest supported request vector; callers cast the mask down to N bits.
    localparam int MAX_N = 32;

    function automatic logic [MAX_N-1:0] onehot_of(input logic [4:0] code);
        return {{(MAX_N-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage

// File: rtl/prio_select.sv
// rtl/prio_select.sv - combinational highest-index select relative to a base pointer
//
// Ports:
//   i_pending  N-bit request vector
//   i_base     rotation base; bit (i_base-1) mod N has highest priority,
//              bit i_base lowest. A base of 0 gives plain highest-index priority.
//   o_code     index of the selected bit (0 when nothing is set)
//   o_any_set  at least one bit of i_pending is set
module prio_select #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_pending,
    input  logic [W-1:0] i_base,
    output logic [W-1:0] o_code,
    output logic         o_any_set
);

    logic [W-1:0] w_rot_idx;

    // Scan the vector in rotated order: position j looks at pending[(j+base) mod N].
    // Later positions overwrite earlier ones, so the highest rotated position wins.
    // W-bit addition wraps naturally because N is a power of two.
    always_comb begin
        w_rot_idx = '0;
        o_any_set = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (i_pending[W'(j) + i_base]) begin
                w_rot_idx = W'(j);
                o_any_set = 1'b1;
            end
        end
    end

    assign o_code = w_rot_idx + i_base;

endmodule

// File: rtl/prio_encoder_hs.sv
// rtl/prio_encoder_hs.sv - registered N-to-log2(N) priority encoder with valid/ready output
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request lines; a high bit at an edge sets the sticky pending bit
//   out_ready  consumer accepts the offered code
//   out_valid  out_code is valid and held stable
//   out_code   index of the granted request
//   pending    sticky pending register
//
// Build option: define PRIO_ENCODER_HS_ROUND_ROBIN_EN for round-robin selection
// (grant the highest pending index strictly below the last granted index, wrapping).
// Otherwise the highest pending index always wins.
module prio_encoder_hs
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic [N-1:0] pending
);

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_code;
    logic [W-1:0] w_code_next;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_pending_next;
    logic [N-1:0] w_clr_mask;
    logic         w_accept;
    logic [W-1:0] w_base;
    logic [W-1:0] w_sel_code;
    logic         w_any_set;

`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
    logic [W-1:0] r_rr_ptr;
    logic [W-1:0] w_rr_next;
    assign w_base = r_rr_ptr;
`else
    assign w_base = '0;
`endif

    prio_select #(.N(N)) u_select (
        .i_pending (r_pending),
        .i_base    (w_base),
        .o_code    (w_sel_code),
        .o_any_set (w_any_set)
    );

    assign w_accept   = (r_state == OFFER) && out_ready;
    assign w_clr_mask = w_accept ? N'(onehot_of(5'(r_code))) : '0;
    // OR-ing req after the clear lets a same-edge request re-arm the granted bit.
    assign w_pending_next = (r_pending & ~w_clr_mask) | req;

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
        w_rr_next    = r_rr_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (w_any_set) begin
                    w_state_next = OFFER;
                    w_code_next  = w_sel_code;
                end
            end
            OFFER: begin
                // Code is frozen while offered; newer requests wait for the next IDLE.
                if (out_ready) begin
                    w_state_next = IDLE;
`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
                    w_rr_next    = r_code;
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_code    <= '0;
            r_pending <= '0;
`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
            r_rr_ptr  <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_code    <= w_code_next;
            r_pending <= w_pending_next;
`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
            r_rr_ptr  <= w_rr_next;
`endif
        end
    end

    assign out_valid = (r_state == OFFER);
    assign out_code  = r_code;
    assign pending   = r_pending;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// tb/tb_prio_encoder_hs.sv - scoreboard bench for prio_encoder_hs
module tb_prio_encoder_hs;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [2:0]   out_code;
    logic [N-1:0] pending;

    prio_encoder_hs #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           v;
        int           c;
        logic [N-1:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: the set of outstanding requests and what is on offer.
    logic [N-1:0] m_pend;
    bit           m_offer;
    int           m_code;
    int           m_rr;
    logic [N-1:0] p_req;
    bit           p_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] p, input int rr);
`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (rr - k + N) % N;
            if (p[idx]) return idx;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (p[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_offer = 1'b0;
        m_code  = 0;
        m_rr    = 0;
        p_req   = '0;
        p_rdy   = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] np;
        np = m_pend;
        if (m_offer && p_rdy) np[m_code] = 1'b0;
        np = np | p_req;
        if (!m_offer) begin
            if (m_pend != '0) begin
                m_code  = pick(m_pend, m_rr);
                m_offer = 1'b1;
            end
        end else if (p_rdy) begin
            m_offer = 1'b0;
            m_rr    = m_code;
        end
        m_pend = np;
    endtask

    // One clock: account for the edge, publish the expected post-edge view,
    // then drive new inputs and predict any accept they cause.
    task automatic cyc(input logic [N-1:0] rq, input bit rdy);
        exp_t e;
        @(posedge clk);
        model_edge();
        #2;
        e.v = m_offer;
        e.c = m_code;
        e.p = m_pend;
        exp_q.push_back(e);
        req       = rq;
        out_ready = rdy;
        p_req     = rq;
        p_rdy     = rdy;
        if (m_offer && rdy) grant_q.push_back(m_code);
    endtask

    task automatic do_reset();
        req       = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        grant_q.delete();
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_code", {29'b0, out_code}, 32'd0);
        chk("async_rst_pending", {24'b0, pending}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_code", {29'b0, out_code}, 32'd0);
            chk("rst_pending", {24'b0, pending}, 32'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("valid", {31'b0, out_valid}, {31'b0, e.v});
                chk("pending", {24'b0, pending}, {24'b0, e.p});
                if (e.v) chk("code", {29'b0, out_code}, 32'(e.c));
            end
            if (out_valid && out_ready) begin
                glog.push_back(int'(out_code));
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", {29'b0, out_code}, 32'hFFFF_FFFF);
                end else begin
                    chk("grant", {29'b0, out_code}, 32'(grant_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1;
        do_reset();

        // Single request, consumer always ready.
        cyc(8'h10, 1'b1);
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b1);

        // Priority with stall, then drain 5, 2, 1.
        cyc(8'h26, 1'b0);
        for (int i = 0; i < 6; i++) cyc(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cyc(8'h00, 1'b1);

        // No retraction while offering code 2.
        cyc(8'h04, 1'b0);
        cyc(8'h00, 1'b0);
        cyc(8'h80, 1'b0);
        cyc(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) cyc(8'h00, 1'b1);

        // Set wins on a same-edge request for the granted bit.
        cyc(8'h08, 1'b0);
        cyc(8'h00, 1'b0);
        cyc(8'h08, 1'b1);
        for (int i = 0; i < 5; i++) cyc(8'h00, 1'b1);

        // Saturated requests from a fresh pointer.
        cyc(8'h00, 1'b0);
        #1;
        do_reset();
        glog.delete();
        for (int i = 0; i < 20; i++) cyc(8'hFF, 1'b1);
        @(negedge clk);
        #1;
        chk("sat_grant_count_ge8", {31'b0, glog.size() >= 8}, 32'd1);
        if (glog.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
                chk("sat_rr_seq", 32'(glog[k]), 32'(7 - k));
`else
                chk("sat_fixed_seq", 32'(glog[k]), 32'd7);
`endif
            end
        end
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] rq;
            rq = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cyc(rq, $urandom_range(0, 2) != 0);
        end

        // Reset mid-offer.
        cyc(8'h40, 1'b0);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);
        #1;
        chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b1);
        cyc(8'h01, 1'b1);
        for (int i = 0; i < 5; i++) cyc(8'h00, 1'b1);

        @(negedge clk);
        #1;
        chk("drain_grants", 32'(grant_q.size()), 32'd0);
        chk("drain_expect", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_encoder_hs.md
Name: prio_encoder_hs

Overview:
- Registered 8-to-3 priority encoder with a valid/ready output handshake. It is the encode-side counterpart of the team's 3-to-8 select decoder.
- Request lines are latched into a sticky pending register. The highest-priority pending request is offered as a binary code and held stable until a consumer accepts it.
- Sits between event/request sources and any block that consumes a binary select.

Parameters:
- N, 8, number of request lines (power of two, 2..32)
- W, $clog2(N), code width; derived localparam, not overridable

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request pulses or levels; bit i high at an edge sets pending[i]
- out_ready  input  1  consumer accepts the offered code
- out_valid  output  1  out_code is valid and stable
- out_code  output  W  index of the granted request
- pending  output  N  current sticky pending register (observability)

Behaviour:
- Reset (async assert, sync release): pending=0, out_valid=0, out_code=0, state=IDLE, rr_ptr=0.
- Pending update at each edge: pending_next = (pending & ~clr_mask) | req.
  - clr_mask is one-hot(out_code) only on an accept edge (out_valid & out_ready); otherwise 0.
  - Set wins: a req on the bit being cleared in the same edge leaves that bit set, so it is granted again later.
- Priority (default): highest index wins; pending=8'b0010_0110 grants code 5.
- FSM, 2 states:
  - IDLE: out_valid=0. If pending!=0 at the edge, load out_code=select(pending), set out_valid=1, go to OFFER. Otherwise stay. The req of the same edge is not seen by selection; selection uses the registered pending only.
  - OFFER: out_valid=1, out_code held constant. If out_ready at the edge, clear the granted bit, set out_valid=0, go to IDLE. Otherwise stay; a new higher-priority req does NOT change out_code (no retraction).
- Latency: req high at edge k sets pending after k. out_valid rises after edge k+1, giving 2 cycles from req to out_valid.
- Throughput: at most one grant per 2 cycles, because IDLE is a mandatory bubble.
- out_ready while out_valid=0 is ignored.
- Reset mid-OFFER: out_valid drops immediately (async) and all pending requests are lost.
- All pending bits high: grants descend 7,6,...,0 over 16 cycles with out_ready tied high.

Optional Feature:
- Macro: PRIO_ENCODER_HS_ROUND_ROBIN_EN.
- Defined:
  - A W-bit rr_ptr register tracks the last granted index (reset 0).
  - Selection picks the pending bit with the highest index strictly below rr_ptr, wrapping from 0 to N-1; rr_ptr itself has lowest priority.
  - rr_ptr updates to out_code on each accept.
  - Guarantees no starvation under continuous requests.
- Undefined: fixed highest-index priority; rr_ptr is not instantiated.
- Port list is identical in both builds.

Decomposition:
- Shared package prio_enc_pkg: state enum {IDLE, OFFER}, and a function onehot_of(code) returning an N-bit mask.
- Sub-module prio_select is natural: purely combinational, inputs pending and base pointer, outputs code and any_set. The round-robin build feeds it a rotated vector; the fixed build ties the base to 0.

Test Plan:
- Reset then idle: rst_n low 3 cycles, req=0 -> out_valid=0, out_code=0, pending=0 throughout; asserting rst_n low mid-cycle clears outputs without a clock edge.
- Single request: req=8'h10 for one cycle, out_ready=1 -> pending=8'h10 after 1 edge, out_valid=1 with out_code=4 after 2 edges, pending=0 and out_valid=0 after 3 edges.
- Priority and stall: pending=8'h26, out_ready=0 for 5 cycles -> out_code=5 held stable with out_valid=1. Then out_ready=1 -> grants 5, 2, 1 in order, each followed by one idle cycle.
- No retraction: in OFFER with code 2, pulse req=8'h80 -> out_code stays 2 until accepted; next grant is 7.
- Set-wins collision: in OFFER with code 3, out_ready=1 and req=8'h08 on the same edge -> pending[3] remains 1 and code 3 is offered again.
- Round-robin build: pending forced to 8'hFF with req held at 8'hFF, out_ready=1 -> grant sequence 7,6,5,4,3,2,1,0,7... with no index repeated within 8 grants; the fixed build under the same stimulus repeats 7 forever.
